// File: rtl/arb_suma.sv
// Two-requester round-robin arbiter sharing a single 4-bit ripple adder.
// The winner's sum is registered with its ID and held until the consumer accepts it.

module sumfa #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];
endmodule

module arb_suma #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         res_valid,
  output logic [W-1:0] res_s,
  output logic         res_cout,
  output logic         res_id,
  input  logic         res_ready
);
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   res_s_q, res_s_d;
  logic           res_cout_q, res_cout_d;
  logic           res_id_q, res_id_d;
  logic           last_id_q, last_id_d;

  logic           win_id;
  logic           can_accept;
  logic           grant;
  logic [W-1:0]   add_a, add_b, add_s;
  logic           add_cout;

  // Arbitration and operand mux; readies are held low while in reset.
  always_comb begin
    win_id     = 1'b0;
    can_accept = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant      = 1'b0;
    add_a      = req0_a;
    add_b      = req0_b;

    if (req0_valid && req1_valid) begin
      win_id = ~last_id_q;
    end else begin
      win_id = req1_valid;
    end

    can_accept = rst_n && ((state_q == IDLE) || res_ready);
    req0_ready = can_accept && req0_valid && !win_id;
    req1_ready = can_accept && req1_valid && win_id;
    grant      = req0_ready || req1_ready;

    if (win_id) begin
      add_a = req1_a;
      add_b = req1_b;
    end
  end

  sumfa #(.W(W)) u_sumfa (
    .a    (add_a),
    .b    (add_b),
    .s    (add_s),
    .cout (add_cout)
  );

  // Result register and state update; a drained result keeps its stale payload.
  always_comb begin
    state_d    = state_q;
    res_s_d    = res_s_q;
    res_cout_d = res_cout_q;
    res_id_d   = res_id_q;
    last_id_d  = last_id_q;

    if (grant) begin
      state_d    = HOLD;
      res_s_d    = add_s;
      res_cout_d = add_cout;
      res_id_d   = win_id;
      last_id_d  = win_id;
    end else if ((state_q == HOLD) && res_ready) begin
      state_d    = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      res_s_q    <= W'(0);
      res_cout_q <= 1'b0;
      res_id_q   <= 1'b0;
      last_id_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      res_s_q    <= res_s_d;
      res_cout_q <= res_cout_d;
      res_id_q   <= res_id_d;
      last_id_q  <= last_id_d;
    end
  end

  assign res_valid = (state_q == HOLD);
  assign res_s     = res_s_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
endmodule

// File: tb/tb_arb_suma.sv
// Bench for arb_suma: directed stimulus, a per-cycle reference model of the
// arbiter/result register, and literal expectations along the directed sequence.

module tb_arb_suma;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
  logic       req0_ready, req1_ready;
  logic       res_valid, res_cout, res_id;
  logic [3:0] res_s;
  logic       res_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  arb_suma #(.W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_s      (res_s),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .res_ready  (res_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents of the result slot plus round-robin history.
  logic       m_valid, m_cout, m_id, m_last;
  logic [3:0] m_s;

  function automatic logic [1:0] exp_readies();
    logic can, r0, r1;
    can = rst_n && (!m_valid || res_ready);
    r0  = can && req0_valid && (!req1_valid || m_last == 1'b1);
    r1  = can && req1_valid && (!req0_valid || m_last == 1'b0);
    return {r1, r0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_s     <= 4'd0;
      m_cout  <= 1'b0;
      m_id    <= 1'b0;
      m_last  <= 1'b1;
    end else begin
      logic [1:0] r;
      int         sum;
      r = exp_readies();
      if (r != 2'b00) begin
        sum     = r[1] ? (int'(req1_a) + int'(req1_b)) : (int'(req0_a) + int'(req0_b));
        m_valid <= 1'b1;
        m_s     <= 4'(sum % 16);
        m_cout  <= (sum >= 16);
        m_id    <= r[1];
        m_last  <= r[1];
      end else if (m_valid && res_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] r;
    r = exp_readies();
    chk("m_req0_ready", 8'(req0_ready), 8'(r[0]));
    chk("m_req1_ready", 8'(req1_ready), 8'(r[1]));
    chk("m_res_valid",  8'(res_valid),  8'(m_valid));
    chk("m_res_s",      8'(res_s),      8'(m_s));
    chk("m_res_cout",   8'(res_cout),   8'(m_cout));
    chk("m_res_id",     8'(res_id),     8'(m_id));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with both requesters contending.
    req0_valid = 1'b1; req0_a = 4'b0001; req0_b = 4'b0001;
    req1_valid = 1'b1; req1_a = 4'b0010; req1_b = 4'b0010;
    res_ready  = 1'b1;
    #1;
    chk("rst_r0", 8'(req0_ready), 8'd0);
    chk("rst_r1", 8'(req1_ready), 8'd0);
    chk("rst_valid", 8'(res_valid), 8'd0);
    step(); step();
    chk("rst_r0_hold", 8'(req0_ready), 8'd0);
    chk("rst_s", 8'(res_s), 8'd0);
    rst_n = 1'b1;
    #1;
    chk("first_grant_r0", 8'(req0_ready), 8'd1);

    // Contention alternates 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_valid", 8'(res_valid), 8'd1);
      chk("alt_id", 8'(res_id), 8'(i % 2));
      chk("alt_s", 8'(res_s), (i % 2 == 0) ? 8'd2 : 8'd4);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("drain_valid", 8'(res_valid), 8'd0);
    chk("drain_stale_s", 8'(res_s), 8'd4);
    chk("drain_stale_id", 8'(res_id), 8'd1);

    // Single op with carry.
    req0_valid = 1'b1; req0_a = 4'b0111; req0_b = 4'b1011;
    step();
    req0_valid = 1'b0;
    chk("single_valid", 8'(res_valid), 8'd1);
    chk("single_s", 8'(res_s), 8'b0010);
    chk("single_cout", 8'(res_cout), 8'd1);
    chk("single_id", 8'(res_id), 8'd0);
    step();
    chk("single_after", 8'(res_valid), 8'd0);

    // Backpressure: hold 0010+0010 from req1 while a new req1 op waits.
    req1_valid = 1'b1; req1_a = 4'b0010; req1_b = 4'b0010;
    step();
    chk("bp_s", 8'(res_s), 8'b0100);
    res_ready = 1'b0;
    req1_a = 4'b0011; req1_b = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_r1_low", 8'(req1_ready), 8'd0);
      step();
      chk("bp_s_stable", 8'(res_s), 8'b0100);
      chk("bp_valid", 8'(res_valid), 8'd1);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_r1", 8'(req1_ready), 8'd1);
    step();
    chk("bp_new_s", 8'(res_s), 8'd7);
    chk("bp_new_id", 8'(res_id), 8'd1);
    chk("bp_new_valid", 8'(res_valid), 8'd1);

    // Wrap-around and zero.
    req1_a = 4'b1111; req1_b = 4'b0001;
    step();
    chk("wrap_s", 8'(res_s), 8'd0);
    chk("wrap_cout", 8'(res_cout), 8'd1);
    chk("wrap_id", 8'(res_id), 8'd1);
    req1_a = 4'b0000; req1_b = 4'b0000;
    step();
    chk("zero_s", 8'(res_s), 8'd0);
    chk("zero_cout", 8'(res_cout), 8'd0);
    chk("zero_valid", 8'(res_valid), 8'd1);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 4'b1111; req0_b = 4'b1111;
    step();
    chk("max_s", 8'(res_s), 8'b1110);
    chk("max_cout", 8'(res_cout), 8'd1);
    chk("max_id", 8'(res_id), 8'd0);

    // Async reset while holding a result.
    req0_valid = 1'b0;
    res_ready  = 1'b0;
    #2;
    chk("pre_rst_valid", 8'(res_valid), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 8'(res_valid), 8'd0);
    chk("async_rst_s", 8'(res_s), 8'd0);
    step();
    req0_valid = 1'b1; req0_a = 4'b0001; req0_b = 4'b0001;
    req1_valid = 1'b1; req1_a = 4'b0010; req1_b = 4'b0010;
    res_ready  = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_r0", 8'(req0_ready), 8'd1);
    chk("post_rst_r1", 8'(req1_ready), 8'd0);
    step();
    chk("post_rst_id", 8'(res_id), 8'd0);
    chk("post_rst_s", 8'(res_s), 8'd2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
